weight_update_scheduler: RTL

Sequences one training-update pass over the weight memory. For each address it reads the old weight, presents it to the Manhattan or Adam update engine, waits for the result, and writes the result back through the training-mode weight mux. It owns the memory read/write strobes, the mux select and the Adam engine handshake, and sits between the training top-level control and the weight-update datapath.

---
 rtl/weight_update_scheduler.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/weight_update_scheduler.sv
// Weight-update pass sequencer: read each weight, run Manhattan or Adam update, write back.
// Optional Adam wait timeout is compiled in when ADAM_TIMEOUT_EN is defined.
module weight_update_scheduler #(
  parameter int unsigned BIT_WIDTH    = 32,
  parameter int unsigned EXTRA_BIT    = 2,
  parameter int unsigned ADDR_WIDTH   = 8,
  parameter int unsigned NUM_WEIGHTS  = 256,
  parameter int unsigned ADAM_TIMEOUT = 64
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic                            training_mode,
  output logic                            mem_rd_en,
  output logic [ADDR_WIDTH-1:0]           mem_addr,
  input  logic [BIT_WIDTH+EXTRA_BIT-1:0]  mem_rd_data,
  output logic [BIT_WIDTH+EXTRA_BIT-1:0]  old_weight,
  output logic                            mode_sel,
  output logic                            adam_start,
  input  logic                            adam_done,
  output logic                            mem_wr_en,
  output logic                            busy,
  output logic                            done,
  output logic                            err
);

  localparam int unsigned WORD_W = BIT_WIDTH + EXTRA_BIT;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_WEIGHTS - 1);

  if (NUM_WEIGHTS < 1 || ADAM_TIMEOUT < 1) begin : g_bad_cfg
    $error("weight_update_scheduler: NUM_WEIGHTS and ADAM_TIMEOUT must be >= 1");
  end

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    LAT  = 3'd2,
    CALC = 3'd3,
    WAIT = 3'd4,
    WR   = 3'd5,
    FIN  = 3'd6
  } state_t;

  state_t                  state_q, state_n;
  logic [ADDR_WIDTH-1:0]   addr_n;
  logic                    mode_n;
  logic [WORD_W-1:0]       old_n;

`ifdef ADAM_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(ADAM_TIMEOUT + 1);
  logic [TMO_W-1:0] wait_q, wait_n;
  logic             err_n;
`endif

  // Next-state and next-register values; mem_addr doubles as the address counter.
  always_comb begin
    state_n = state_q;
    addr_n  = mem_addr;
    mode_n  = mode_sel;
    old_n   = old_weight;
`ifdef ADAM_TIMEOUT_EN
    wait_n  = wait_q;
    err_n   = err;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          mode_n  = training_mode;
          addr_n  = '0;
          state_n = RD;
`ifdef ADAM_TIMEOUT_EN
          err_n   = 1'b0;
`endif
        end
      end
      RD:   state_n = LAT;
      LAT: begin
        old_n   = mem_rd_data;
        state_n = CALC;
      end
      CALC: begin
`ifdef ADAM_TIMEOUT_EN
        wait_n  = '0;
`endif
        state_n = mode_sel ? WR : WAIT;
      end
      WAIT: begin
        if (adam_done) begin
          state_n = WR;
        end
`ifdef ADAM_TIMEOUT_EN
        else if (wait_q == TMO_W'(ADAM_TIMEOUT - 1)) begin
          err_n   = 1'b1;
          state_n = FIN;
        end else begin
          wait_n  = wait_q + TMO_W'(1);
        end
`endif
      end
      WR: begin
        if (mem_addr == LAST_ADDR) begin
          state_n = FIN;
        end else begin
          addr_n  = mem_addr + ADDR_WIDTH'(1);
          state_n = RD;
        end
      end
      FIN:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they belong to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      mem_addr   <= '0;
      mode_sel   <= 1'b0;
      old_weight <= '0;
      mem_rd_en  <= 1'b0;
      mem_wr_en  <= 1'b0;
      adam_start <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state_q    <= state_n;
      mem_addr   <= addr_n;
      mode_sel   <= mode_n;
      old_weight <= old_n;
      mem_rd_en  <= (state_n == RD);
      mem_wr_en  <= (state_n == WR);
      adam_start <= (state_n == CALC) && !mode_n;
      busy       <= (state_n inside {RD, LAT, CALC, WAIT, WR});
      done       <= (state_n == FIN);
    end
  end

`ifdef ADAM_TIMEOUT_EN
  // WAIT-cycle counter and sticky timeout flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_q <= '0;
      err    <= 1'b0;
    end else begin
      wait_q <= wait_n;
      err    <= err_n;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule
